// File: rtl/lamp_sequencer.sv
// lamp_sequencer
//   Parametrised N-lamp driver with four display modes: static, blink, chase and
//   fill-bar. Animations advance on a clock-divided step tick. Both outputs are
//   registered from internal state, so any state change made at edge k (load or
//   step) appears on the outputs after edge k+1.
// Ports
//   clk        in   1         system clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   num        in   IW        lamp index (STATIC/BLINK) or sequence length (CHASE/FILL), 1-based
//   mode       in   2         0 STATIC, 1 BLINK, 2 CHASE, 3 FILL
//   load       in   1         sample num/mode, restart animation (wins over a coincident step)
//   enable     in   1         1: step tick runs; 0: animation frozen
//   lamp_data  out  N_LAMPS   lamp drive, bit i-1 = lamp i, polarity set by ACTIVE_LOW
//   wrap       out  1         one-cycle pulse when a CHASE/FILL sequence restarts
module lamp_sequencer #(
  parameter  int N_LAMPS    = 8,
  parameter  int TICK_DIV   = 4,
  parameter  int ACTIVE_LOW = 1,
  localparam int IW         = $clog2(N_LAMPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IW-1:0]      num,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic               enable,
  output logic [N_LAMPS-1:0] lamp_data,
  output logic               wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0]      NUM_MAX   = IW'(N_LAMPS);
  localparam logic [N_LAMPS-1:0] LAMP_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_BLINK  = 2'd1,
    M_CHASE  = 2'd2,
    M_FILL   = 2'd3
  } mode_t;

  mode_t           r_mode;
  logic [IW-1:0]   r_num;
  logic [IW-1:0]   r_pos;
  logic            r_phase;
  logic [TW-1:0]   r_tick_cnt;
  logic            r_wrap_evt;

  logic [IW-1:0]      w_len;
  logic               w_step;
  logic               w_step_live;
  logic [N_LAMPS-1:0] w_lit;

  // Out-of-range lengths collapse to 0, which blanks the display and freezes steps.
  assign w_len       = (r_num != '0 && r_num <= NUM_MAX) ? r_num : '0;
  assign w_step      = enable && (r_tick_cnt == TICK_LAST);
  assign w_step_live = w_step && (w_len != '0);

  always_comb begin
    w_lit = '0;
    for (int unsigned i = 0; i < N_LAMPS; i++) begin
      case (r_mode)
        M_STATIC: w_lit[i] = (IW'(i + 1) == w_len);
        M_BLINK:  w_lit[i] = (IW'(i + 1) == w_len) && r_phase;
        M_CHASE:  w_lit[i] = (IW'(i + 1) == r_pos) && (w_len != '0);
        M_FILL:   w_lit[i] = (IW'(i + 1) <= r_pos) && (w_len != '0);
        default:  w_lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= M_STATIC;
      r_num      <= '0;
      r_pos      <= '0;
      r_phase    <= 1'b0;
      r_tick_cnt <= '0;
      r_wrap_evt <= 1'b0;
      lamp_data  <= LAMP_OFF;
      wrap       <= 1'b0;
    end else begin
      lamp_data  <= (ACTIVE_LOW != 0) ? ~w_lit : w_lit;
      // The restart is flagged one edge early so wrap lines up with the
      // first registered frame of the restarted pattern.
      wrap       <= r_wrap_evt;
      r_wrap_evt <= 1'b0;
      if (load) begin
        r_num      <= num;
        r_mode     <= mode_t'(mode);
        r_tick_cnt <= '0;
        r_phase    <= 1'b1;
        r_pos      <= (mode == 2'd2 || mode == 2'd3) ? IW'(1) : '0;
      end else begin
        if (enable) begin
          r_tick_cnt <= w_step ? '0 : r_tick_cnt + 1'b1;
        end
        if (w_step_live) begin
          case (r_mode)
            M_BLINK: r_phase <= ~r_phase;
            M_CHASE: begin
              if (r_pos == w_len) begin
                r_pos      <= IW'(1);
                r_wrap_evt <= 1'b1;
              end else begin
                r_pos <= r_pos + 1'b1;
              end
            end
            M_FILL: begin
              if (r_pos == w_len) begin
                r_pos      <= '0;
                r_wrap_evt <= 1'b1;
              end else begin
                r_pos <= r_pos + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lamp_sequencer.sv
module tb_lamp_sequencer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] num = '0;
  logic [1:0] mode = '0;
  logic [7:0] lamp_data;
  logic       wrap;

  lamp_sequencer #(.N_LAMPS(8), .TICK_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .num      (num),
    .mode     (mode),
    .load     (load),
    .enable   (enable),
    .lamp_data(lamp_data),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] lamp;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int wrap_seen = 0;

  // reference model state
  int m_num, m_mode, m_pos, m_phase, m_tick, m_wevt;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_num = 0; m_mode = 0; m_pos = 0; m_phase = 0; m_tick = 0; m_wevt = 0;
  endtask

  // Active-high lit pattern for the current model state.
  function automatic logic [7:0] model_lit();
    int len;
    int t;
    len = (m_num >= 1 && m_num <= N) ? m_num : 0;
    t = 0;
    if (len != 0) begin
      case (m_mode)
        0: t = 1 << (len - 1);
        1: t = (m_phase != 0) ? (1 << (len - 1)) : 0;
        2: t = (m_pos >= 1) ? (1 << (m_pos - 1)) : 0;
        default: t = (1 << m_pos) - 1;
      endcase
    end
    return t[7:0];
  endfunction

  // One clock: push expected output, advance model, clock DUT, pop and compare.
  task automatic cyc();
    exp_t e;
    int   len;
    logic stp;
    e.lamp = ~model_lit();
    e.wrap = (m_wevt != 0);
    exp_q.push_back(e);
    len  = (m_num >= 1 && m_num <= N) ? m_num : 0;
    stp  = enable && (m_tick == 3);
    m_wevt = 0;
    if (load) begin
      m_num   = int'(num);
      m_mode  = int'(mode);
      m_tick  = 0;
      m_phase = 1;
      m_pos   = (mode >= 2'd2) ? 1 : 0;
    end else begin
      if (enable) m_tick = (m_tick == 3) ? 0 : m_tick + 1;
      if (stp && len != 0) begin
        case (m_mode)
          1: m_phase = 1 - m_phase;
          2: if (m_pos == len) begin m_pos = 1; m_wevt = 1; end else m_pos++;
          3: if (m_pos == len) begin m_pos = 0; m_wevt = 1; end else m_pos++;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("lamp", lamp_data, e.lamp);
    check_val("wrap", {7'b0, wrap}, {7'b0, e.wrap});
    if (wrap === 1'b1) wrap_seen++;
  endtask

  task automatic drive_load(input int n, input int md);
    num  = 4'(n);
    mode = 2'(md);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  // Reset asserted between clock edges: outputs must go unlit without an edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_val("rst_async_lamp", lamp_data, 8'hFF);
    check_val("rst_async_wrap", {7'b0, wrap}, 8'h00);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    check_val("rst_hold_lamp", lamp_data, 8'hFF);
    rst = 1'b0;
  endtask

  initial begin
    logic full;
    int   guard;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    repeat (3) cyc();
    check_val("idle_after_rst", lamp_data, 8'hFF);

    // STATIC
    drive_load(3, 0);
    cyc();
    check_val("static3", lamp_data, 8'hFB);
    repeat (6) cyc();
    drive_load(9, 0);
    repeat (2) cyc();
    check_val("static9", lamp_data, 8'hFF);
    drive_load(0, 0);
    repeat (2) cyc();
    check_val("static0", lamp_data, 8'hFF);

    // CHASE num=3
    enable = 1'b1;
    wrap_seen = 0;
    drive_load(3, 2);
    cyc();
    check_val("chase_first", lamp_data, 8'hFE);
    repeat (24) cyc();
    check_val("chase_wrap_lamp", lamp_data, 8'hFE);
    check_val("chase_wrap_bit", {7'b0, wrap}, 8'h01);
    check_val("chase_wraps", wrap_seen[7:0], 8'd2);

    // FILL num=2
    drive_load(2, 3);
    cyc();
    check_val("fill2_first", lamp_data, 8'hFE);
    repeat (8) cyc();
    check_val("fill2_empty", lamp_data, 8'hFF);
    check_val("fill2_wrap", {7'b0, wrap}, 8'h01);
    repeat (6) cyc();

    // FILL num=8 must reach all lit
    drive_load(8, 3);
    full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (lamp_data === 8'h00) full = 1'b1;
    end
    check_val("fill8_full", {7'b0, full}, 8'h01);

    // BLINK num=5 with freeze
    drive_load(5, 1);
    cyc();
    check_val("blink_on", lamp_data, 8'hEF);
    repeat (5) cyc();
    enable = 1'b0;
    repeat (20) cyc();
    check_val("blink_frozen", lamp_data, 8'hFF);
    enable = 1'b1;
    repeat (10) cyc();

    // load coinciding with a step
    drive_load(4, 2);
    repeat (5) cyc();
    guard = 0;
    while (m_tick != 3 && guard < 8) begin
      cyc();
      guard++;
    end
    check_val("align_step", {7'b0, guard < 8}, 8'h01);
    wrap_seen = 0;
    drive_load(4, 2);
    cyc();
    check_val("coincide_restart", lamp_data, 8'hFE);
    repeat (2) cyc();
    check_val("coincide_nowrap", wrap_seen[7:0], 8'd0);

    // reset mid-CHASE
    repeat (6) cyc();
    do_reset();
    repeat (10) cyc();
    check_val("post_rst_off", lamp_data, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
